instr_fetch: RTL and testbench

- Multicycle fetch stage that owns the PC and the instruction register (IR).
- On a control pulse, reads one 32-bit word from instruction memory using a req/ready handshake, latches it into the IR and advances the PC.
- ir_o drives the immediate generator's ir_i and the decode/control matrix directly.
- pc_prev_o gives the address of the instruction currently held in the IR, used for AUIPC, branch and JAL targets.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_wait_counter.sv | 30 +++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, fault cause codes, reset NOP.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_MISALIGN = 2'b10;

    // addi x0,x0,0 -- harmless instruction held in the IR out of reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_wait_counter.sv
// Wait-cycle counter for an outstanding fetch, flags the last allowed wait cycle.
// Latency: count updates one cycle after en_i; tc_o is combinational from the count.
// Backpressure: none; clr_i has priority over en_i, TIMEOUT_CYCLES=0 never flags.
module fetch_wait_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TC_VAL = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CW-1:0] count;

    // Count wait cycles; cleared whenever no request is waiting
    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            count <= '0;
        end else if (en_i) begin
            count <= count + 1'b1;
        end
    end

    assign tc_o = (TIMEOUT_CYCLES != 0) && (count == CW'(TC_VAL));

endmodule

// File: rtl/instr_fetch.sv
// Multicycle fetch stage: owns PC and IR, reads one word per fetch_i pulse.
// Latency: fetch_i to ir_valid_o is 2 cycles minimum (REQ entered, then handshake).
// Backpressure: holds mem_rd_o in REQ until mem_rdy_i or timeout; optional FETCH_ALIGN_CHECK_EN faults misaligned PCs.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int                  TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fetch_i,
    input  logic                  pc_ld_i,
    input  logic [DATA_WIDTH-1:0] pc_next_i,
    output logic                  mem_rd_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rdy_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] ir_o,
    output logic                  ir_valid_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_prev_o,
    output logic                  busy_o,
    output logic                  fault_o,
    output logic [1:0]            fault_cause_o
);

    fetch_state_t          state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_prev;
    logic [DATA_WIDTH-1:0] ir;
    logic                  ir_valid;
    logic                  mem_rd;
    logic                  busy;
    logic                  fault;
    logic [1:0]            fault_cause;
    logic                  wait_tc;
    logic                  align_err;

`ifdef FETCH_ALIGN_CHECK_EN
    // A simultaneous PC load redirects the fetch, so check the address actually used
    logic [DATA_WIDTH-1:0] fetch_addr;
    assign fetch_addr = pc_ld_i ? pc_next_i : pc;
    assign align_err  = (fetch_addr[1:0] != 2'b00);
    assign mem_addr_o = pc;
`else
    assign align_err  = 1'b0;
    assign mem_addr_o = {pc[DATA_WIDTH-1:2], 2'b00};
`endif

    fetch_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   ((state != REQ) || mem_rdy_i),
        .en_i    ((state == REQ) && !mem_rdy_i),
        .tc_o    (wait_tc)
    );

    // Fetch FSM with PC/IR update and registered handshake/status outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            pc_prev     <= RESET_VECTOR;
            ir          <= DATA_WIDTH'(NOP_INSTR);
            ir_valid    <= 1'b0;
            mem_rd      <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_ld_i) begin
                        pc <= pc_next_i;
                    end
                    if (fetch_i) begin
                        ir_valid <= 1'b0;
                        if (align_err) begin
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= FC_MISALIGN;
                        end else begin
                            state  <= REQ;
                            mem_rd <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_rdy_i) begin
                        ir       <= mem_data_i;
                        pc_prev  <= pc;
                        pc       <= pc + DATA_WIDTH'(4);
                        ir_valid <= 1'b1;
                        mem_rd   <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_tc) begin
                        mem_rd      <= 1'b0;
                        busy        <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                        state       <= FAULT;
                    end
                end
                FAULT: begin
                    // sticky until reset; PC and IR frozen
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ir_o          = ir;
    assign ir_valid_o    = ir_valid;
    assign pc_o          = pc;
    assign pc_prev_o     = pc_prev;
    assign mem_rd_o      = mem_rd;
    assign busy_o        = busy;
    assign fault_o       = fault;
    assign fault_cause_o = fault_cause;

`ifdef SIMULATE
    // Control must not issue fetch or PC load while a read is outstanding
    always_ff @(posedge clk_i) begin
        if (!reset_i && state == REQ) begin
            assert (!(fetch_i || pc_ld_i))
                else $error("fetch_i/pc_ld_i asserted while fetch in progress");
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level model.
// Latency: drives one fetch transaction at a time and checks every REQ cycle.
// Backpressure: memory ready delay randomized, including timeouts.
module tb_instr_fetch;

    localparam int          TO  = 15;
    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        fetch_i;
    logic        pc_ld_i;
    logic [31:0] pc_next_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_rdy_i;
    logic [31:0] mem_data_i;
    logic [31:0] ir_o;
    logic        ir_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_prev_o;
    logic        busy_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    int checks   = 0;
    int failures = 0;

    // transaction-level model of architectural state
    logic [31:0] m_pc, m_prev, m_ir;
    logic        m_valid, m_fault;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    instr_fetch #(
        .DATA_WIDTH     (32),
        .RESET_VECTOR   (RV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .fetch_i       (fetch_i),
        .pc_ld_i       (pc_ld_i),
        .pc_next_i     (pc_next_i),
        .mem_rd_o      (mem_rd_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdy_i     (mem_rdy_i),
        .mem_data_i    (mem_data_i),
        .ir_o          (ir_o),
        .ir_valid_o    (ir_valid_o),
        .pc_o          (pc_o),
        .pc_prev_o     (pc_prev_o),
        .busy_o        (busy_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pc = RV; m_prev = RV; m_ir = NOP;
        m_valid = 1'b0; m_fault = 1'b0; m_cause = 2'b00;
    endtask

    // Compare every architectural output against the model while not in REQ
    task automatic check_state(input string tag);
        check_eq({tag, ".ir"},    ir_o,                  m_ir);
        check_eq({tag, ".vld"},   32'(ir_valid_o),       32'(m_valid));
        check_eq({tag, ".pc"},    pc_o,                  m_pc);
        check_eq({tag, ".prev"},  pc_prev_o,             m_prev);
        check_eq({tag, ".fault"}, 32'(fault_o),          32'(m_fault));
        check_eq({tag, ".cause"}, 32'(fault_cause_o),    32'(m_cause));
        check_eq({tag, ".rd"},    32'(mem_rd_o),         32'd0);
        check_eq({tag, ".busy"},  32'(busy_o),           32'd0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; fetch_i = 1'b0; pc_ld_i = 1'b0; mem_rdy_i = 1'b0;
        tick();
        reset_i = 1'b0;
        model_reset();
        check_state("reset");
    endtask

    task automatic do_load(input logic [31:0] nxt);
        pc_ld_i = 1'b1; pc_next_i = nxt;
        tick();
        pc_ld_i = 1'b0;
        m_pc = nxt;
        check_eq("load.pc", pc_o, m_pc);
    endtask

    // One fetch transaction: memory answers after wait_n stalled cycles
    task automatic do_fetch(input logic ld, input logic [31:0] nxt, input int wait_n,
                            input logic [31:0] data, input string tag);
        logic [31:0] addr;
        logic [31:0] exp_addr;
        addr = ld ? nxt : m_pc;
        fetch_i = 1'b1; pc_ld_i = ld; pc_next_i = nxt; mem_rdy_i = 1'b0;
        tick();
        fetch_i = 1'b0; pc_ld_i = 1'b0;
        m_valid = 1'b0;
        m_pc = addr;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_addr = addr;
        if (addr[1:0] != 2'b00) begin
            m_fault = 1'b1; m_cause = 2'b10;
            check_state({tag, ".mis"});
            return;
        end
`else
        exp_addr = {addr[31:2], 2'b00};
`endif
        for (int c = 0; c < TO; c++) begin
            check_eq({tag, ".req_busy"}, 32'(busy_o),     32'd1);
            check_eq({tag, ".req_rd"},   32'(mem_rd_o),   32'd1);
            check_eq({tag, ".req_addr"}, mem_addr_o,      exp_addr);
            check_eq({tag, ".req_ir"},   ir_o,            m_ir);
            check_eq({tag, ".req_vld"},  32'(ir_valid_o), 32'd0);
            if (c == wait_n) begin
                mem_rdy_i = 1'b1; mem_data_i = data;
                tick();
                mem_rdy_i = 1'b0; mem_data_i = $urandom;
                m_ir = data; m_prev = addr; m_pc = addr + 32'd4; m_valid = 1'b1;
                break;
            end
            mem_data_i = $urandom;
            tick();
            if (c == TO - 1) begin
                m_fault = 1'b1; m_cause = 2'b01;
            end
        end
        check_state({tag, ".done"});
    endtask

    initial begin
        reset_i = 1'b1; fetch_i = 1'b0; pc_ld_i = 1'b0; pc_next_i = '0;
        mem_rdy_i = 1'b0; mem_data_i = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // immediate ready
        do_fetch(1'b0, 32'h0, 0, 32'h0050_0093, "t1");
        check_eq("t1.pc_abs", pc_o, 32'h4);
        check_eq("t1.prev_abs", pc_prev_o, 32'h0);

        // three wait cycles
        do_fetch(1'b0, 32'h0, 3, 32'hFE00_0EE3, "t2");
        check_eq("t2.pc_abs", pc_o, 32'h8);

        // fetch with simultaneous PC load
        do_fetch(1'b1, 32'h100, 1, $urandom, "t3");
        check_eq("t3.pc_abs", pc_o, 32'h104);
        check_eq("t3.prev_abs", pc_prev_o, 32'h100);

        // PC wrap
        do_load(32'hFFFF_FFFC);
        do_fetch(1'b0, 32'h0, 0, $urandom, "t5");
        check_eq("t5.wrap", pc_o, 32'h0);

        // misaligned PC: faults with the check, masked address without
        do_load(32'h102);
        do_fetch(1'b0, 32'h0, 0, $urandom, "t5b");
        do_reset();

        // timeout, then fetch/load ignored in FAULT
        do_fetch(1'b0, 32'h0, 1000, 32'h0, "t4");
        check_eq("t4.cause_abs", 32'(fault_cause_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            fetch_i = 1'b1; pc_ld_i = 1'b1; pc_next_i = $urandom;
            tick();
            fetch_i = 1'b0; pc_ld_i = 1'b0;
            check_state("t4.frozen");
        end
        do_reset();

        // reset in the middle of REQ, late ready ignored
        do_fetch(1'b0, 32'h0, 0, 32'h1234_5678, "t6a");
        fetch_i = 1'b1;
        tick();
        fetch_i = 1'b0;
        tick();
        check_eq("t6.busy_mid", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_eq("t6.rd_after_rst", 32'(mem_rd_o), 32'd0);
        mem_rdy_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
        tick();
        mem_rdy_i = 1'b0;
        model_reset();
        check_state("t6");

        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                do_load($urandom & 32'hFFFF_FFFC);
            end else if (r == 9) begin
                do_fetch(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                         $urandom_range(TO, TO + 5), $urandom, "rnd_to");
                do_reset();
            end else begin
                do_fetch(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                         $urandom_range(0, 5), $urandom, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
